// File: rtl/xalu_ise_issue.sv
// Core-side issuer for the custom-instruction ALU port: registers one request onto ise_*, returns result/illegal.
// Optional macro XALU_ISE_TIMEOUT_EN lets EXEC wait up to TIMEOUT cycles for ise_oval.
module xalu_ise_issue #(
  parameter int TIMEOUT = 15
) (
  input  logic        ise_clk,
  input  logic        ise_rst,
  input  logic        flush,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_fn,
  input  logic [6:0]  req_imm,
  input  logic [63:0] req_rs1,
  input  logic [63:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [4:0]  ise_fn,
  output logic [6:0]  ise_imm,
  output logic [63:0] ise_in1,
  output logic [63:0] ise_in2,
  output logic        ise_val,
  input  logic        ise_oval,
  input  logic [63:0] ise_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_illegal,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state, next_state;
  logic [4:0]  op_fn;
  logic [6:0]  op_imm;
  logic [63:0] op_in1, op_in2;
  logic [4:0]  op_rd;
  logic [63:0] res_data;
  logic        res_illegal;
  logic        load_op, cap_result, cap_illegal;

  generate
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("xalu_ise_issue: TIMEOUT must be in 1..255");
    end
  endgenerate

`ifdef XALU_ISE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       cnt_inc;
`endif

  always_comb begin
    next_state  = state;
    load_op     = 1'b0;
    cap_result  = 1'b0;
    cap_illegal = 1'b0;
    req_ready   = 1'b0;
`ifdef XALU_ISE_TIMEOUT_EN
    cnt_inc     = 1'b0;
`endif
    case (state)
      IDLE: begin
        req_ready = !flush;
        if (req_valid && !flush) begin
          load_op    = 1'b1;
          next_state = EXEC;
        end
      end
      EXEC: begin
        if (ise_oval) begin
          cap_result = 1'b1;
          next_state = RESP;
        end else begin
`ifdef XALU_ISE_TIMEOUT_EN
          if (wait_cnt == TIMEOUT_LAST) begin
            cap_illegal = 1'b1;
            next_state  = RESP;
          end else begin
            cnt_inc = 1'b1;
          end
`else
          cap_illegal = 1'b1;
          next_state  = RESP;
`endif
        end
      end
      RESP: begin
        req_ready = rsp_ready && !flush;
        if (rsp_ready) begin
          if (req_valid) begin
            load_op    = 1'b1;
            next_state = EXEC;
          end else begin
            next_state = IDLE;
          end
        end
      end
      default: next_state = IDLE;
    endcase
    // An abort drops the in-flight instruction and any pending response.
    if (flush) begin
      next_state  = IDLE;
      load_op     = 1'b0;
      cap_result  = 1'b0;
      cap_illegal = 1'b0;
`ifdef XALU_ISE_TIMEOUT_EN
      cnt_inc     = 1'b0;
`endif
    end
  end

  always_ff @(posedge ise_clk) begin
    if (ise_rst) begin
      state       <= IDLE;
      op_fn       <= '0;
      op_imm      <= '0;
      op_in1      <= '0;
      op_in2      <= '0;
      op_rd       <= '0;
      res_data    <= '0;
      res_illegal <= 1'b0;
    end else begin
      state <= next_state;
      if (load_op) begin
        op_fn  <= req_fn;
        op_imm <= req_imm;
        op_in1 <= req_rs1;
        op_in2 <= req_rs2;
        op_rd  <= req_rd;
      end
      if (cap_result) begin
        res_data    <= ise_out;
        res_illegal <= 1'b0;
      end else if (cap_illegal) begin
        res_data    <= '0;
        res_illegal <= 1'b1;
      end
    end
  end

`ifdef XALU_ISE_TIMEOUT_EN
  always_ff @(posedge ise_clk) begin
    if (ise_rst || flush || load_op) begin
      wait_cnt <= '0;
    end else if (cnt_inc) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end
`endif

  assign ise_fn      = op_fn;
  assign ise_imm     = op_imm;
  assign ise_in1     = op_in1;
  assign ise_in2     = op_in2;
  assign ise_val     = (state == EXEC);
  assign rsp_valid   = (state == RESP);
  assign rsp_data    = res_data;
  assign rsp_rd      = op_rd;
  assign rsp_illegal = res_illegal;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_xalu_ise_issue.sv
// Directed bench for xalu_ise_issue with a stub ALU and a response scoreboard.
// Timeout scenarios run only when XALU_ISE_TIMEOUT_EN is defined.
module tb_xalu_ise_issue;

  logic        ise_clk = 1'b0;
  logic        ise_rst, flush, req_valid, req_ready;
  logic [4:0]  req_fn, req_rd, ise_fn, rsp_rd;
  logic [6:0]  req_imm, ise_imm;
  logic [63:0] req_rs1, req_rs2, ise_in1, ise_in2, ise_out, rsp_data;
  logic        ise_val, ise_oval, rsp_valid, rsp_ready, rsp_illegal, busy;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        illegal;
  } exp_t;
  exp_t sb[$];

  int stub_delay = 0;
  int exec_cnt   = 0;

  always #5 ise_clk = ~ise_clk;

  xalu_ise_issue #(.TIMEOUT(4)) dut (
    .ise_clk(ise_clk), .ise_rst(ise_rst), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fn(req_fn), .req_imm(req_imm), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
    .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2),
    .ise_val(ise_val), .ise_oval(ise_oval), .ise_out(ise_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_rd(rsp_rd), .rsp_illegal(rsp_illegal), .busy(busy)
  );

  // Stub ALU: claims any nonzero funct7 after stub_delay EXEC cycles; result is in1+in2.
  always @(posedge ise_clk) exec_cnt <= ise_val ? exec_cnt + 1 : 0;
  assign ise_oval = ise_val && (ise_imm != 7'd0) && (exec_cnt == stub_delay);
  assign ise_out  = ise_oval ? (ise_in1 + ise_in2) : 64'hBADB_ADBA_DBAD_BAD0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [4:0] fn, input logic [6:0] imm,
                               input logic [63:0] rs1, input logic [63:0] rs2, input logic [4:0] rd);
    req_valid = valid;
    req_fn    = fn;
    req_imm   = imm;
    req_rs1   = rs1;
    req_rs2   = rs2;
    req_rd    = rd;
  endtask

  task automatic cyc();
    @(posedge ise_clk);
    #1;
  endtask

  // Scoreboard: expectations pushed on each accepted request, popped on each response handshake.
  always @(negedge ise_clk) begin
    if (!ise_rst && rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_rsp", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("sb_rsp_data", rsp_data, e.data);
        checkOutput("sb_rsp_rd", {59'd0, rsp_rd}, {59'd0, e.rd});
        checkOutput("sb_rsp_illegal", {63'd0, rsp_illegal}, {63'd0, e.illegal});
      end
    end
    if (!ise_rst && req_valid === 1'b1 && req_ready === 1'b1) begin
      exp_t e;
      e.illegal = (req_imm == 7'd0);
      e.data    = e.illegal ? 64'd0 : (req_rs1 + req_rs2);
      e.rd      = req_rd;
      sb.push_back(e);
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] simulation timed out");
  end

  initial begin
    logic [4:0]  b_rd  [4];
    logic [63:0] b_rs1 [4];

    ise_rst = 1'b1;
    flush = 1'b0;
    rsp_ready = 1'b1;
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    cyc();
    cyc();
    ise_rst = 1'b0;
    @(negedge ise_clk);
    checkOutput("rst_ise_val", {63'd0, ise_val}, 64'd0);
    checkOutput("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    checkOutput("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_req_ready", {63'd0, req_ready}, 64'd1);
    checkOutput("rst_ise_in1", ise_in1, 64'd0);
    checkOutput("rst_rsp_data", rsp_data, 64'd0);
    checkOutput("rst_rsp_rd", {59'd0, rsp_rd}, 64'd0);

    // Legal op: accept at N, ise_val in N+1, rsp_valid in N+2.
    cyc();
    applyStimulus(1'b1, 5'b00001, 7'b1000011, 64'hDEAD_BEEF_0000_0000, 64'h1, 5'd10);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    @(negedge ise_clk);
    checkOutput("legal_ise_val", {63'd0, ise_val}, 64'd1);
    checkOutput("legal_ise_imm", {57'd0, ise_imm}, 64'h43);
    checkOutput("legal_ise_fn", {59'd0, ise_fn}, 64'd1);
    checkOutput("legal_ise_in1", ise_in1, 64'hDEAD_BEEF_0000_0000);
    checkOutput("legal_ise_in2", ise_in2, 64'h1);
    checkOutput("legal_busy", {63'd0, busy}, 64'd1);
    checkOutput("legal_req_ready_exec", {63'd0, req_ready}, 64'd0);
    checkOutput("legal_no_early_rsp", {63'd0, rsp_valid}, 64'd0);
    cyc();
    @(negedge ise_clk);
    checkOutput("legal_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("legal_rsp_data", rsp_data, 64'hDEAD_BEEF_0000_0001);
    checkOutput("legal_rsp_rd", {59'd0, rsp_rd}, 64'd10);
    checkOutput("legal_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
    cyc();
    @(negedge ise_clk);
    checkOutput("legal_idle_busy", {63'd0, busy}, 64'd0);

    // Illegal op: nobody claims funct7 == 0.
    cyc();
    applyStimulus(1'b1, 5'b00010, 7'd0, 64'd5, 64'd7, 5'd3);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    @(negedge ise_clk);
    checkOutput("illegal_ise_val", {63'd0, ise_val}, 64'd1);
    cyc();
    @(negedge ise_clk);
    checkOutput("illegal_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("illegal_flag", {63'd0, rsp_illegal}, 64'd1);
    checkOutput("illegal_data", rsp_data, 64'd0);
    cyc();

    // Backpressure: response held for 3 cycles, pending request waits.
    rsp_ready = 1'b0;
    applyStimulus(1'b1, 5'd3, 7'd5, 64'd100, 64'd23, 5'd7);
    cyc();
    applyStimulus(1'b1, 5'd4, 7'd9, 64'd1000, 64'd1, 5'd8);
    cyc();
    for (int i = 0; i < 3; i++) begin
      @(negedge ise_clk);
      checkOutput("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("bp_rsp_data", rsp_data, 64'd123);
      checkOutput("bp_rsp_rd", {59'd0, rsp_rd}, 64'd7);
      checkOutput("bp_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);
      checkOutput("bp_req_ready", {63'd0, req_ready}, 64'd0);
      if (i < 2) cyc();
    end
    cyc();
    rsp_ready = 1'b1;
    @(negedge ise_clk);
    checkOutput("bp_release_req_ready", {63'd0, req_ready}, 64'd1);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    @(negedge ise_clk);
    checkOutput("bp_next_ise_val", {63'd0, ise_val}, 64'd1);
    checkOutput("bp_next_ise_in1", ise_in1, 64'd1000);
    cyc();
    cyc();

    // Back-to-back: 4 requests, responses every other cycle.
    for (int i = 0; i < 4; i++) begin
      b_rd[i]  = 5'(11 + i);
      b_rs1[i] = 64'h1000 * 64'(i + 1);
    end
    applyStimulus(1'b1, 5'd0, 7'd1, b_rs1[0], 64'd0, b_rd[0]);
    for (int i = 0; i < 4; i++) begin
      cyc();
      @(negedge ise_clk);
      checkOutput("b2b_ise_val", {63'd0, ise_val}, 64'd1);
      checkOutput("b2b_ise_in1", ise_in1, b_rs1[i]);
      if (i < 3) applyStimulus(1'b1, 5'(i + 1), 7'(i + 2), b_rs1[i + 1], 64'(i + 1), b_rd[i + 1]);
      else       applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
      cyc();
      @(negedge ise_clk);
      checkOutput("b2b_rsp_valid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("b2b_rsp_rd", {59'd0, rsp_rd}, {59'd0, b_rd[i]});
    end
    cyc();
    @(negedge ise_clk);
    checkOutput("b2b_idle_busy", {63'd0, busy}, 64'd0);

    // Flush during EXEC aborts with no response.
    cyc();
    applyStimulus(1'b1, 5'd1, 7'd1, 64'd55, 64'd66, 5'd4);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    flush = 1'b1;
    @(negedge ise_clk);
    checkOutput("flush_exec_ise_val", {63'd0, ise_val}, 64'd1);
    void'(sb.pop_back());
    cyc();
    flush = 1'b0;
    @(negedge ise_clk);
    checkOutput("flush_ise_val_after", {63'd0, ise_val}, 64'd0);
    checkOutput("flush_busy_after", {63'd0, busy}, 64'd0);
    checkOutput("flush_rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
    cyc();
    @(negedge ise_clk);
    checkOutput("flush_no_late_rsp", {63'd0, rsp_valid}, 64'd0);

    // Flush in IDLE blocks a simultaneous request.
    flush = 1'b1;
    applyStimulus(1'b1, 5'd2, 7'd3, 64'd9, 64'd9, 5'd9);
    @(negedge ise_clk);
    checkOutput("flush_idle_req_ready", {63'd0, req_ready}, 64'd0);
    cyc();
    flush = 1'b0;
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    @(negedge ise_clk);
    checkOutput("flush_idle_busy", {63'd0, busy}, 64'd0);
    checkOutput("flush_idle_ise_val", {63'd0, ise_val}, 64'd0);

    // Reset during EXEC aborts as well.
    cyc();
    applyStimulus(1'b1, 5'd1, 7'd2, 64'd1, 64'd2, 5'd5);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    ise_rst = 1'b1;
    void'(sb.pop_back());
    cyc();
    ise_rst = 1'b0;
    @(negedge ise_clk);
    checkOutput("rst_exec_ise_val", {63'd0, ise_val}, 64'd0);
    checkOutput("rst_exec_busy", {63'd0, busy}, 64'd0);

`ifdef XALU_ISE_TIMEOUT_EN
    // Multi-cycle unit claims on the 3rd EXEC cycle.
    stub_delay = 2;
    cyc();
    applyStimulus(1'b1, 5'd1, 7'd4, 64'd40, 64'd2, 5'd6);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge ise_clk);
      checkOutput("to_wait_ise_val", {63'd0, ise_val}, 64'd1);
      checkOutput("to_wait_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      cyc();
    end
    @(negedge ise_clk);
    checkOutput("to_claim_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("to_claim_illegal", {63'd0, rsp_illegal}, 64'd0);
    cyc();

    // Nobody claims: illegal after TIMEOUT EXEC cycles.
    applyStimulus(1'b1, 5'd1, 7'd0, 64'd40, 64'd2, 5'd2);
    cyc();
    applyStimulus(1'b0, 5'd0, 7'd0, 64'd0, 64'd0, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge ise_clk);
      checkOutput("to_never_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      cyc();
    end
    @(negedge ise_clk);
    checkOutput("to_expire_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    checkOutput("to_expire_illegal", {63'd0, rsp_illegal}, 64'd1);
    cyc();
    stub_delay = 0;
`endif

    cyc();
    @(negedge ise_clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/xalu_ise_issue.md
# xalu_ise_issue

Core-side issuer for the custom-instruction ALU port. It accepts one decoded custom instruction at a time from the execute stage and registers its function, immediate and operands onto the `ise_*` request bus. It samples `ise_oval`/`ise_out` and returns either a result or an illegal-instruction flag to writeback through a valid/ready handshake. It sits between the core execute stage and the ISE ALU, and is the initiating end of the `ise_*` interface.

## Interface
- `TIMEOUT`, 15: maximum EXEC cycles spent waiting for `ise_oval`. Used only with `XALU_ISE_TIMEOUT_EN`. Legal range 1..255.
- `ise_clk` in 1: clock; all logic is rising-edge.
- `ise_rst` in 1: synchronous, active-high reset.
- `flush` in 1: synchronous abort of the in-flight instruction.
- `req_valid` in 1: execute stage presents an instruction.
- `req_ready` out 1: instruction accepted this cycle when both valid and ready are high.
- `req_fn` in 5: custom opcode select; bits [1:0] carry the CUSTOM_0..3 slot.
- `req_imm` in 7: funct7 field.
- `req_rs1`, `req_rs2` in 64 each: source operand values.
- `req_rd` in 5: destination register index.
- `ise_fn` out 5, `ise_imm` out 7, `ise_in1` out 64, `ise_in2` out 64: registered request to the ALU.
- `ise_val` out 1: request valid.
- `ise_oval` in 1: ALU claims the operation.
- `ise_out` in 64: ALU result.
- `rsp_valid` out 1: response to writeback.
- `rsp_ready` in 1: writeback accepts.
- `rsp_data` out 64: result; 0 when illegal.
- `rsp_rd` out 5: destination index.
- `rsp_illegal` out 1: no ALU unit claimed the opcode.
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP.
- **IDLE**
  - `req_ready`=1.
  - On accept: latch `req_fn`/`req_imm`/`req_rs1`/`req_rs2`/`req_rd` into operand registers, then go to EXEC.
- **EXEC**
  - `ise_val`=1.
  - `ise_*` outputs are driven directly from the operand registers, which stay stable for the whole state.
  - If `ise_oval`=1: capture `ise_out` into the result register, set illegal=0, go to RESP.
  - If `ise_oval`=0 and the macro is absent: set result=0, illegal=1, go to RESP.
- **RESP**
  - `rsp_valid`=1. `rsp_data`, `rsp_rd` and `rsp_illegal` are held stable until `rsp_ready`=1.
  - On `rsp_ready` with `req_valid`: accept the new request and go straight to EXEC. `req_ready` = IDLE | (RESP & `rsp_ready`).
  - On `rsp_ready` without `req_valid`: go to IDLE.
- **flush**
  - Priority is below `ise_rst` and above everything else.
  - Next state is IDLE; any pending response is discarded and the timeout counter is cleared.
  - `req_ready` is forced to 0 during the flush cycle, so a request presented in that cycle is not accepted.
- Operand registers keep their last values in IDLE. The ALU ignores them because `ise_val`=0.

## Timing
- **Reset values:** state IDLE; `ise_val`, `rsp_valid`, `rsp_illegal`, `busy` = 0; `req_ready`=1 (IDLE, no flush). `ise_fn`, `ise_imm`, `ise_in1`, `ise_in2`, `rsp_data`, `rsp_rd` = 0.
- **Base latency:** accept at edge N; `ise_val` high during cycle N+1; `rsp_valid` high during cycle N+2.
- **Throughput:** with `rsp_ready` tied high and `req_valid` continuous, one instruction every 2 cycles.
- **Backpressure:** `rsp_valid` stays high and the response is unchanged while `rsp_ready`=0. No new request is accepted during this time.
- **Reset or flush in EXEC:** `ise_val` is 0 in the following cycle. No response is ever produced for the aborted instruction.

## Configuration
- Macro: `XALU_ISE_TIMEOUT_EN`.
- **Defined:**
  - An 8-bit wait counter clears on entry to EXEC and increments each EXEC cycle without `ise_oval`.
  - When the counter equals `TIMEOUT-1` and `ise_oval`=0, the instruction is marked illegal and the FSM goes to RESP.
  - EXEC therefore lasts 1..TIMEOUT cycles, which supports multi-cycle ALU units.
- **Undefined:**
  - No counter exists; `ise_oval` is sampled only in the single EXEC cycle.
  - The `TIMEOUT` parameter is ignored.

## Test plan
- **Legal op:** `req_fn`=5'b00001, `req_imm`=7'b1000011, `req_rd`=10, stub ALU returns `ise_oval`=1 and `ise_out`=64'hDEAD_BEEF_0000_0001 → `ise_val` at N+1 with `ise_imm`=7'b1000011; `rsp_valid` at N+2 with that data, `rsp_rd`=10, `rsp_illegal`=0.
- **Illegal op:** `req_imm`=7'b0000000, stub `ise_oval`=0 → at N+2 `rsp_illegal`=1, `rsp_data`=0.
- **Backpressure:** `rsp_ready`=0 for 3 cycles → response held bit-stable, `req_ready`=0; releasing `rsp_ready` with `req_valid`=1 gives `ise_val` on the next cycle.
- **Back-to-back:** 4 requests with `rsp_ready`=1 → responses in cycles 2, 4, 6, 8 in order, with matching `rsp_rd`.
- **Flush:** flush during EXEC → `ise_val`=0 next cycle, no `rsp_valid`, `busy`=0. Flush coinciding with `req_valid` in IDLE → request not accepted.
- **Timeout (macro defined):**
  - `TIMEOUT`=4, stub asserts `ise_oval` on the 3rd EXEC cycle → `rsp_valid` at N+4, `rsp_illegal`=0.
  - Stub never asserts `ise_oval` → `rsp_illegal`=1 at N+5.
